axil_reg_responder: RTL

- AXI4-Lite subordinate (responder) on the far end of the s_axil_* bus that the HLS-generated read/write initiators drive.
- Backs the bus with a word-addressed register bank.
- Exposes the debug_addr/debug_data/debug_wr_* side port so benches and hosts can peek and poke the bank directly.
- Independent read and write channels; one outstanding transaction per channel.

---
 rtl/axil_pkg.sv | 45 ++++
 rtl/axil_if.sv | 43 ++++
 rtl/axil_regfile.sv | 73 +++++++
 rtl/axil_reg_responder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axil_pkg
// Brief   : Shared AXI4-Lite response codes, channel state types and helpers.
// Revision: 1.0
// ============================================================================
package axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
    localparam int         AXIL_DATA_WIDTH  = 32;
    localparam int         AXIL_STRB_WIDTH  = 4;

    typedef enum logic [2:0] {
        WR_EMPTY   = 3'd0,
        WR_HAVE_AW = 3'd1,
        WR_HAVE_W  = 3'd2,
        WR_FULL    = 3'd3,
        WR_RESP    = 3'd4
    } wr_state_e;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

    function automatic logic [AXIL_DATA_WIDTH-1:0] strb_merge(
        input logic [AXIL_DATA_WIDTH-1:0] old_word,
        input logic [AXIL_DATA_WIDTH-1:0] new_word,
        input logic [AXIL_STRB_WIDTH-1:0] strb
    );
        logic [AXIL_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < AXIL_STRB_WIDTH; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned num_regs);
        return idx < num_regs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_if.sv
`default_nettype none
// ============================================================================
// Module  : axil_if
// Brief   : AXI4-Lite bus bundle with initiator (master) and responder (slave) views.
// Revision: 1.0
// ============================================================================
interface axil_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axil_regfile.sv
`default_nettype none
// ============================================================================
// Module  : axil_regfile
// Brief   : Word register bank: async debug peek, registered bus read capture,
//           bus (strobed) and debug (full word) write ports; debug wins on collision.
// Revision: 1.0
// ============================================================================
module axil_regfile
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_REGS   = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic [ADDR_WIDTH-1:0]      dbg_rd_addr,
    output logic [AXIL_DATA_WIDTH-1:0]      dbg_rd_data,
    input  wire logic                       cap_en,
    input  wire logic [ADDR_WIDTH-1:0]      cap_addr,
    output logic [AXIL_DATA_WIDTH-1:0]      cap_data,
    input  wire logic                       axi_wr_en,
    input  wire logic [ADDR_WIDTH-1:0]      axi_wr_addr,
    input  wire logic [AXIL_DATA_WIDTH-1:0] axi_wr_data,
    input  wire logic [AXIL_STRB_WIDTH-1:0] axi_wr_strb,
    input  wire logic                       dbg_wr_en,
    input  wire logic [ADDR_WIDTH-1:0]      dbg_wr_addr,
    input  wire logic [AXIL_DATA_WIDTH-1:0] dbg_wr_data
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return idx_in_range(32'(a[ADDR_WIDTH-1:2]), NUM_REGS);
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    logic [AXIL_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [AXIL_DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [AXIL_DATA_WIDTH-1:0] cap_data_q, cap_data_d;
    logic                       w_unused;

    assign w_unused    = &{1'b0, dbg_rd_addr[1:0], cap_addr[1:0], axi_wr_addr[1:0], dbg_wr_addr[1:0]};
    assign dbg_rd_data = in_range(dbg_rd_addr) ? regs_q[idx_of(dbg_rd_addr)] : '0;
    assign cap_data    = cap_data_q;

    always_comb begin
        regs_d     = regs_q;
        cap_data_d = cap_data_q;
        // The capture samples regs_q, so a read sees the value before any same-edge write.
        if (cap_en) begin
            cap_data_d = in_range(cap_addr) ? regs_q[idx_of(cap_addr)] : '0;
        end
        if (axi_wr_en && in_range(axi_wr_addr)) begin
            regs_d[idx_of(axi_wr_addr)] = strb_merge(regs_q[idx_of(axi_wr_addr)], axi_wr_data, axi_wr_strb);
        end
        if (dbg_wr_en && in_range(dbg_wr_addr)) begin
            regs_d[idx_of(dbg_wr_addr)] = dbg_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            cap_data_q <= '0;
        end else begin
            regs_q     <= regs_d;
            cap_data_q <= cap_data_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/axil_reg_responder.sv
`default_nettype none
// ============================================================================
// Module  : axil_reg_responder
// Brief   : AXI4-Lite responder over a word register bank with a debug peek/poke port.
// Revision: 1.0
// ============================================================================
module axil_reg_responder
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = AXIL_DATA_WIDTH,
    parameter int NUM_REGS   = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    axil_if.slave                      s_axil,
    input  wire logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0]      debug_data,
    input  wire logic [ADDR_WIDTH-1:0] debug_wr_addr,
    input  wire logic [DATA_WIDTH-1:0] debug_wr_data,
    input  wire logic                  debug_wr_en
);
    wr_state_e             wr_state_q, wr_state_d;
    rd_state_e             rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [3:0]            w_strb_q, w_strb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  aw_hs, w_hs, ar_hs, wr_commit;
    logic                  w_unused;

    assign w_unused = &{1'b0, s_axil.awprot, s_axil.arprot};

    // Ready flags decode registered state only, so no input reaches them combinationally.
    assign s_axil.awready = (wr_state_q == WR_EMPTY) || (wr_state_q == WR_HAVE_W);
    assign s_axil.wready  = (wr_state_q == WR_EMPTY) || (wr_state_q == WR_HAVE_AW);
    assign s_axil.bvalid  = (wr_state_q == WR_RESP);
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = (rd_state_q == RD_IDLE);
    assign s_axil.rvalid  = (rd_state_q == RD_RESP);
    assign s_axil.rresp   = rresp_q;

    assign aw_hs = s_axil.awvalid && s_axil.awready;
    assign w_hs  = s_axil.wvalid && s_axil.wready;
    assign ar_hs = s_axil.arvalid && s_axil.arready;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bresp_d    = bresp_q;
        wr_commit  = 1'b0;
        if (aw_hs) aw_addr_d = s_axil.awaddr;
        if (w_hs) begin
            w_data_d = s_axil.wdata;
            w_strb_d = s_axil.wstrb;
        end
        case (wr_state_q)
            WR_EMPTY: begin
                if (aw_hs && w_hs) wr_state_d = WR_FULL;
                else if (aw_hs)    wr_state_d = WR_HAVE_AW;
                else if (w_hs)     wr_state_d = WR_HAVE_W;
            end
            WR_HAVE_AW: if (w_hs)  wr_state_d = WR_FULL;
            WR_HAVE_W:  if (aw_hs) wr_state_d = WR_FULL;
            WR_FULL: begin
                wr_commit  = 1'b1;
                bresp_d    = idx_in_range(32'(aw_addr_q[ADDR_WIDTH-1:2]), NUM_REGS)
                             ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
                wr_state_d = WR_RESP;
            end
            WR_RESP: if (s_axil.bready) wr_state_d = WR_EMPTY;
            default: wr_state_d = WR_EMPTY;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (s_axil.arvalid) begin
                    rresp_d    = idx_in_range(32'(s_axil.araddr[ADDR_WIDTH-1:2]), NUM_REGS)
                                 ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: if (s_axil.rready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_q <= WR_EMPTY;
            rd_state_q <= RD_IDLE;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= AXIL_RESP_OKAY;
            rresp_q    <= AXIL_RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
        end
    end

    axil_regfile #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .dbg_rd_addr (debug_addr),
        .dbg_rd_data (debug_data),
        .cap_en      (ar_hs),
        .cap_addr    (s_axil.araddr),
        .cap_data    (s_axil.rdata),
        .axi_wr_en   (wr_commit),
        .axi_wr_addr (aw_addr_q),
        .axi_wr_data (w_data_q),
        .axi_wr_strb (w_strb_q),
        .dbg_wr_en   (debug_wr_en),
        .dbg_wr_addr (debug_wr_addr),
        .dbg_wr_data (debug_wr_data)
    );
endmodule
`default_nettype wire
